// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and decode helpers for the sequential ALU/mul-div block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_XOR    = 5'd2,
        OP_AND    = 5'd3,
        OP_OR     = 5'd4,
        OP_SLL    = 5'd5,
        OP_SRL    = 5'd6,
        OP_SRA    = 5'd7,
        OP_SLT    = 5'd8,
        OP_SLTU   = 5'd9,
        OP_LUI    = 5'd10,
        OP_MUL    = 5'd11,
        OP_MULH   = 5'd12,
        OP_MULHSU = 5'd13,
        OP_MULHU  = 5'd14,
        OP_DIV    = 5'd15,
        OP_DIVU   = 5'd16,
        OP_REM    = 5'd17,
        OP_REMU   = 5'd18
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // First opcode of the multi-cycle group and first opcode that is not defined.
    localparam logic [4:0] OP_MULDIV_MIN  = 5'd11;
    localparam logic [4:0] OP_ILLEGAL_MIN = 5'd19;

    // True for opcodes that go through the iterative multiplier/divider.
    function automatic logic is_muldiv(input logic [4:0] op);
        return (op >= OP_MULDIV_MIN) && (op < OP_ILLEGAL_MIN);
    endfunction

    // True for opcodes handled by the restoring divider.
    function automatic logic is_div(input logic [4:0] op);
        return (op >= OP_DIV) && (op < OP_ILLEGAL_MIN);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier and restoring divider on operand magnitudes, sign fixed at the end.
// Latency: XLEN cycles after start_i; done_o and result_o are valid together in the final iteration cycle.
// Backpressure: none; the owner must consume result_o on done_o, start_i is only honoured when issued.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [4:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam logic [SHW-1:0] LAST = SHW'(XLEN - 1);

    logic              busy_q;
    logic [SHW-1:0]    cnt_q;
    logic [4:0]        op_q;
    logic [XLEN-1:0]   opnd_q;     // multiplicand (mul) or divisor (div) magnitude
    logic [2*XLEN-1:0] acc_q;      // mul: running product; div: {remainder, quotient}
    logic              neg_q;      // negate product / quotient at the end
    logic              rneg_q;     // negate remainder at the end
    logic              bzero_q;    // divisor was zero
    logic [XLEN-1:0]   a_q;        // original dividend, returned by REM on divide-by-zero

    logic              a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift, div_diff;
    logic [XLEN-1:0]   div_rem;
    logic              div_qbit;
    logic [2*XLEN-1:0] acc_d;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo, rem;

    // Operand sign handling at start: work on magnitudes, remember which results to negate.
    always_comb begin
        a_signed = (op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM);
        b_signed = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
        a_neg    = a_signed && a_i[XLEN-1];
        b_neg    = b_signed && b_i[XLEN-1];
        a_mag    = a_neg ? (~a_i + 1'b1) : a_i;
        b_mag    = b_neg ? (~b_i + 1'b1) : b_i;
    end

    // One multiply or divide step per cycle.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : {XLEN{1'b0}})};
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_qbit  = ~div_diff[XLEN];
        div_rem   = div_qbit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
        if (is_div(op_q)) begin
            acc_d = {div_rem, acc_q[XLEN-2:0], div_qbit};
        end else begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    // Final sign fix-up and result selection, taken from the value of the last step.
    always_comb begin
        prod_fix = neg_q ? (~acc_d + 1'b1) : acc_d;
        quo      = acc_d[XLEN-1:0];
        rem      = acc_d[2*XLEN-1:XLEN];
        result_o = '0;
        case (op_q)
            OP_MUL:                      result_o = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result_o = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             result_o = bzero_q ? {XLEN{1'b1}} : (neg_q ? (~quo + 1'b1) : quo);
            OP_REM, OP_REMU:             result_o = bzero_q ? a_q : (rneg_q ? (~rem + 1'b1) : rem);
            default:                     result_o = '0;
        endcase
    end

    assign done_o = busy_q && (cnt_q == LAST);

    // Operand load on start, then one iteration per cycle until the counter reaches XLEN-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            op_q    <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            bzero_q <= 1'b0;
            a_q     <= '0;
        end else if (start_i) begin
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            op_q    <= op_i;
            opnd_q  <= is_div(op_i) ? b_mag : a_mag;
            acc_q   <= {{XLEN{1'b0}}, (is_div(op_i) ? a_mag : b_mag)};
            neg_q   <= a_neg ^ b_neg;
            rneg_q  <= a_neg;
            bzero_q <= (b_i == '0);
            a_q     <= a_i;
        end else if (busy_q) begin
            acc_q  <= acc_d;
            cnt_q  <= done_o ? '0 : cnt_q + SHW'(1);
            busy_q <= ~done_o;
        end
    end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Single-issue ALU with inline basic ops and an iterative mul/div unit behind an IDLE/BUSY/DONE FSM.
// Latency: 1 cycle for basic and illegal ops, XLEN+1 cycles for mul/div ops, accept to rsp_valid.
// Backpressure: result held in DONE until rsp_ready; req_ready low for the whole operation.
module alu_muldiv_seq
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)   // derived from XLEN, leave at default
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] in_alu_a,
    input  logic [XLEN-1:0] in_alu_b,
    input  logic [4:0]      alu_op,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] out_alu
);

    state_e          state_q;
    logic            rsp_valid_q;
    logic [XLEN-1:0] out_q;
    logic            accept;
    logic            op_md;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] basic_d;
    logic            md_done;
    logic [XLEN-1:0] md_result;

    assign req_ready = (state_q == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign op_md     = is_muldiv(alu_op);
    assign shamt     = in_alu_b[SHW-1:0];
    assign rsp_valid = rsp_valid_q;
    assign out_alu   = out_q;

    // Single-cycle ops evaluated straight from the request inputs; undefined opcodes give 0.
    always_comb begin
        basic_d = '0;
        case (alu_op)
            OP_ADD:  basic_d = in_alu_a + in_alu_b;
            OP_SUB:  basic_d = in_alu_a - in_alu_b;
            OP_XOR:  basic_d = in_alu_a ^ in_alu_b;
            OP_AND:  basic_d = in_alu_a & in_alu_b;
            OP_OR:   basic_d = in_alu_a | in_alu_b;
            OP_SLL:  basic_d = in_alu_a << shamt;
            OP_SRL:  basic_d = in_alu_a >> shamt;
            OP_SRA:  basic_d = XLEN'($signed(in_alu_a) >>> shamt);
            OP_SLT:  basic_d = {{(XLEN-1){1'b0}}, ($signed(in_alu_a) < $signed(in_alu_b))};
            OP_SLTU: basic_d = {{(XLEN-1){1'b0}}, (in_alu_a < in_alu_b)};
            OP_LUI:  basic_d = in_alu_b;
            default: basic_d = '0;
        endcase
    end

    alu_muldiv_iter #(
        .XLEN (XLEN),
        .SHW  (SHW)
    ) u_iter (
        .clk      (clk),
        .rst      (rst),
        .start_i  (accept && op_md),
        .op_i     (alu_op),
        .a_i      (in_alu_a),
        .b_i      (in_alu_b),
        .done_o   (md_done),
        .result_o (md_result)
    );

    // Control FSM with registered response; the result register is zeroed whenever no response is shown.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (op_md) begin
                            state_q <= ST_BUSY;
                        end else begin
                            state_q     <= ST_DONE;
                            rsp_valid_q <= 1'b1;
                            out_q       <= basic_d;
                        end
                    end
                end
                ST_BUSY: begin
                    if (md_done) begin
                        state_q     <= ST_DONE;
                        rsp_valid_q <= 1'b1;
                        out_q       <= md_result;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        out_q       <= '0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    rsp_valid_q <= 1'b0;
                    out_q       <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed-vector bench for alu_muldiv_seq at XLEN=32 with hand-computed results and latencies.
// Latency: checks 1 cycle for basic ops, 33 cycles for mul/div.
// Backpressure: exercises held responses, ignored requests and reset abort.
module tb_alu_muldiv_seq;
    import alu_pkg::*;

    localparam int XLEN = 32;
    localparam int LAT_B = 1;
    localparam int LAT_M = XLEN + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] in_alu_a;
    logic [XLEN-1:0] in_alu_b;
    logic [4:0]      alu_op;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] out_alu;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_muldiv_seq #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .in_alu_a  (in_alu_a),
        .in_alu_b  (in_alu_b),
        .alu_op    (alu_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .out_alu   (out_alu)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request, measure accept-to-response latency, check result, then complete the handshake.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input int exp_lat);
        int lat;
        @(negedge clk);
        alu_op    = op;
        in_alu_a  = a;
        in_alu_b  = b;
        req_valid = 1'b1;
        chk({tag, " ready"}, 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        in_alu_a  = 32'hDEAD_BEEF;   // captured operands must not follow the inputs
        in_alu_b  = 32'h1234_5678;
        alu_op    = OP_SUB;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 100);
        chk({tag, " lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, " val"}, 64'(out_alu), 64'(exp));
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk({tag, " idle"}, {62'd0, rsp_valid, req_ready}, 64'd1);
        chk({tag, " zero"}, 64'(out_alu), 64'd0);
    endtask

    initial begin : main
        int hits;
        rst       = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        in_alu_a  = '0;
        in_alu_b  = '0;
        alu_op    = OP_ADD;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst out_alu", 64'(out_alu), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst req_ready", 64'(req_ready), 64'd1);

        // Basic ops
        run_op("add wrap", OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, LAT_B);
        run_op("sub wrap", OP_SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, LAT_B);
        run_op("xor",      OP_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, LAT_B);
        run_op("and",      OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, LAT_B);
        run_op("or",       OP_OR,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, LAT_B);
        run_op("sll mask", OP_SLL,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002, LAT_B);
        run_op("srl",      OP_SRL,  32'h8000_0000, 32'd31,        32'h0000_0001, LAT_B);
        run_op("sra",      OP_SRA,  32'h8000_0000, 32'd31,        32'hFFFF_FFFF, LAT_B);
        run_op("slt",      OP_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1,         LAT_B);
        run_op("sltu",     OP_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0,         LAT_B);
        run_op("lui",      OP_LUI,  32'h0000_0123, 32'hABCD_E000, 32'hABCD_E000, LAT_B);
        run_op("ill 19",   5'd19,   32'd5,         32'd6,         32'd0,         LAT_B);
        run_op("ill 31",   5'd31,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         LAT_B);

        // Multiply
        run_op("mul",      OP_MUL,    32'd7,         32'd6,         32'd42,        LAT_M);
        run_op("mul m1",   OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, LAT_M);
        run_op("mulh min", OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT_M);
        run_op("mulh neg", OP_MULH,   32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, LAT_M);
        run_op("mulhsu",   OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_M);
        run_op("mulhu",    OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_M);

        // Divide
        run_op("div z",    OP_DIV,  32'd7,         32'd0,         32'hFFFF_FFFF, LAT_M);
        run_op("rem z",    OP_REM,  32'd7,         32'd0,         32'd7,         LAT_M);
        run_op("div nz",   OP_DIV,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, LAT_M);
        run_op("rem nz",   OP_REM,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, LAT_M);
        run_op("divu z",   OP_DIVU, 32'd7,         32'd0,         32'hFFFF_FFFF, LAT_M);
        run_op("remu z",   OP_REMU, 32'd7,         32'd0,         32'd7,         LAT_M);
        run_op("div ovf",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_M);
        run_op("rem ovf",  OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         LAT_M);
        run_op("div neg",  OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, LAT_M);
        run_op("rem neg",  OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, LAT_M);
        run_op("divu",     OP_DIVU, 32'd100,       32'd7,         32'd14,        LAT_M);
        run_op("remu",     OP_REMU, 32'd100,       32'd7,         32'd2,         LAT_M);

        // Backpressure: response held, second request ignored while DONE
        @(negedge clk);
        alu_op = OP_ADD; in_alu_a = 32'd2; in_alu_b = 32'd3; req_valid = 1'b1;
        @(posedge clk);
        #1;
        alu_op = OP_ADD; in_alu_a = 32'd100; in_alu_b = 32'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp hold val", 64'(out_alu), 64'd5);
            chk("bp hold rdy", {62'd0, rsp_valid, req_ready}, 64'd2);
        end
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        hits = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid) hits++;
        end
        chk("bp no extra rsp", 64'(hits), 64'd0);
        chk("bp idle ready", 64'(req_ready), 64'd1);

        // Reset in BUSY cycle 10 of DIVU aborts the operation
        @(negedge clk);
        alu_op = OP_DIVU; in_alu_a = 32'd100; in_alu_b = 32'd7; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;   // no effect outside DONE
        repeat (10) @(negedge clk);
        chk("abort busy rdy", {62'd0, rsp_valid, req_ready}, 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("abort idle", {62'd0, rsp_valid, req_ready}, 64'd1);
        chk("abort out", 64'(out_alu), 64'd0);
        hits = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) hits++;
        end
        chk("abort no rsp", 64'(hits), 64'd0);
        run_op("post rst add", OP_ADD, 32'd2, 32'd3, 32'd5, LAT_B);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
